// File: rtl/end_signal_pkg.sv
// Shared types and constants for the end-of-step completion barrier.
package end_signal_pkg;

    // Barrier FSM states: waiting for reports, emitting the pulse, parked.
    typedef enum logic [1:0] {
        ARMED = 2'd0,
        PULSE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_CH      = 5;
    localparam int DEF_PULSE_LEN = 1;
    localparam int DEF_TIMEOUT_W = 16;

    // Width needed for a counter that must hold the value len itself.
    function automatic int pulse_cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/done_capture_reg.sv
// Sticky per-channel report register with participation mask.
// all_done looks at the current-cycle strobes too, so completion is seen
// in the same cycle the last report arrives.
module done_capture_reg #(
    parameter int N_CH = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_en,
    input  logic            clear,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [N_CH-1:0] sig,
    output logic [N_CH-1:0] flags,
    output logic            all_done
);

    logic [N_CH-1:0] flags_reg;
    logic [N_CH-1:0] met;

    // A channel is satisfied if it already reported, reports now, or is masked off.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_met
            assign met[gi] = flags_reg[gi] | sig[gi] | ~ch_mask[gi];
        end
    endgenerate

    // Latch enabled reports; clear has priority over capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_reg <= '0;
        end else if (clear) begin
            flags_reg <= '0;
        end else if (capture_en) begin
            flags_reg <= flags_reg | (sig & ch_mask);
        end
    end

    assign flags    = flags_reg;
    assign all_done = (&met) && (ch_mask != '0);

endmodule

// File: rtl/end_signal_barrier.sv
// Completion barrier: issues one end-of-step pulse once every enabled
// channel has reported, with re-arm, one-shot/repeat and a watchdog.
module end_signal_barrier
    import end_signal_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W,
    parameter int ONE_SHOT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH-1:0]      sig,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 sig_out,
    output logic                 timeout,
    output logic                 busy,
    output logic [N_CH-1:0]      done_flags
);

    localparam int PC_W = pulse_cnt_width(PULSE_LEN);

    state_t               state_reg, state_next;
    logic [PC_W-1:0]      pulse_cnt_reg, pulse_cnt_next;
    logic [TIMEOUT_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic                 sig_out_reg, sig_out_next;
    logic                 timeout_reg, timeout_next;
    logic                 flag_clear;
    logic                 capture_en;
    logic                 all_done;
    logic [TIMEOUT_W-1:0] wd_limit;

    // Reports are only taken while armed; a start cycle discards them.
    assign capture_en = (state_reg == ARMED) && !start;
    assign wd_limit   = timeout_cycles - TIMEOUT_W'(1);

    done_capture_reg #(
        .N_CH(N_CH)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .capture_en(capture_en),
        .clear     (flag_clear),
        .ch_mask   (ch_mask),
        .sig       (sig),
        .flags     (done_flags),
        .all_done  (all_done)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARMED;
            pulse_cnt_reg <= '0;
            wd_cnt_reg    <= '0;
            sig_out_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pulse_cnt_reg <= pulse_cnt_next;
            wd_cnt_reg    <= wd_cnt_next;
            sig_out_reg   <= sig_out_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Next-state logic: start beats everything, completion beats the watchdog.
    always_comb begin
        state_next     = state_reg;
        pulse_cnt_next = pulse_cnt_reg;
        wd_cnt_next    = wd_cnt_reg;
        sig_out_next   = sig_out_reg;
        timeout_next   = timeout_reg;
        flag_clear     = 1'b0;
        if (start) begin
            state_next     = ARMED;
            pulse_cnt_next = '0;
            wd_cnt_next    = '0;
            sig_out_next   = 1'b0;
            timeout_next   = 1'b0;
            flag_clear     = 1'b1;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (all_done) begin
                        state_next     = PULSE;
                        sig_out_next   = 1'b1;
                        pulse_cnt_next = PC_W'(1);
                        wd_cnt_next    = '0;
                    end else if ((timeout_cycles != '0) && (wd_cnt_reg == wd_limit)) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                        wd_cnt_next  = '0;
                        flag_clear   = 1'b1;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + TIMEOUT_W'(1);
                    end
                end
                PULSE: begin
                    // The entry cycle counts as the first pulse cycle.
                    if (pulse_cnt_reg == PC_W'(PULSE_LEN)) begin
                        sig_out_next   = 1'b0;
                        pulse_cnt_next = '0;
                        wd_cnt_next    = '0;
                        flag_clear     = 1'b1;
                        state_next     = (ONE_SHOT != 0) ? DONE : ARMED;
                    end else begin
                        pulse_cnt_next = pulse_cnt_reg + PC_W'(1);
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = ARMED;
                end
            endcase
        end
    end

    assign sig_out = sig_out_reg;
    assign timeout = timeout_reg;
    assign busy    = (state_reg == ARMED);

endmodule

// File: doc/end_signal_barrier.md
Name: end_signal_barrier

Overview:
- Parametrised completion barrier for the real-time solver pipeline: N_CH per-channel "step done" strobes are captured individually, and one end-of-step pulse is issued once every enabled channel has reported.
- Channels need not report in the same cycle; each report is latched.
- Adds over the fixed 5-input AND-and-pulse generation:
  - per-channel enable mask
  - programmable pulse length
  - re-arm via start
  - one-shot/repeat mode
  - watchdog timeout
  - status flags
- Sits between the solver sub-blocks' done outputs and the step sequencer's start input.

Parameters:
- N_CH, 5, number of done inputs (1..32)
- PULSE_LEN, 1, cycles sig_out is held high per completion (>=1)
- TIMEOUT_W, 16, width of the timeout counter/limit
- ONE_SHOT, 1, 1: after a pulse, wait in DONE until start; 0: auto re-arm after pulse

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  synchronous re-arm/clear strobe
- ch_mask  in  N_CH  1 = channel participates; sampled every cycle
- sig  in  N_CH  per-channel done strobes (pulse or level)
- timeout_cycles  in  TIMEOUT_W  watchdog limit in ARMED cycles; 0 = disabled
- sig_out  out  1  end-of-step pulse, registered
- timeout  out  1  sticky watchdog flag, registered
- busy  out  1  high while ARMED
- done_flags  out  N_CH  latched per-channel reports

Behaviour:
- Reset values:
  - rst=1 asynchronously forces state=ARMED, done_flags=0, sig_out=0, timeout=0, counters=0.
  - busy=1 after reset, since the block comes out of reset armed, as the legacy block did.
- States: ARMED, PULSE, DONE.
- ARMED:
  - done_flags <= done_flags | (sig & ch_mask) each cycle.
  - all_done = &((done_flags | sig) | ~ch_mask) && (ch_mask != 0); includes current-cycle sig.
  - On all_done: next state PULSE, sig_out <= 1, so sig_out is high the cycle after the last report (latency 1).
  - ch_mask == 0: never completes; stays ARMED (the watchdog may still fire).
  - Mask changes take effect immediately. Flags of masked-off channels are kept but ignored.
- PULSE:
  - sig_out stays high for exactly PULSE_LEN cycles total (pulse counter width $clog2(PULSE_LEN+1)).
  - sig inputs are ignored (not captured) in PULSE and DONE.
  - At the end of the pulse, sig_out <= 0 and done_flags <= 0.
  - Next state: ONE_SHOT=1 → DONE; ONE_SHOT=0 → ARMED.
- DONE: all outputs low except done_flags = 0 and timeout (sticky); stays until start or rst.
- Watchdog:
  - Counter increments each ARMED cycle and clears on entering ARMED.
  - If timeout_cycles != 0 and count reaches timeout_cycles - 1 without all_done: timeout <= 1 (sticky until start/rst), state <= DONE, no sig_out.
  - all_done and timeout in the same cycle: completion wins, timeout stays 0.
- start (any state): next cycle state=ARMED, done_flags=0, sig_out=0, timeout=0, counters=0. sig in the start cycle is discarded.
  - start has priority over completion, pulse continuation and timeout in the same cycle.
  - start mid-pulse truncates the pulse.
- rst mid-operation: immediate return to reset values. No partial pulse is completed.

Decomposition:
- Shared package end_signal_pkg:
  - state enum (ARMED, PULSE, DONE)
  - default N_CH/PULSE_LEN/TIMEOUT_W constants
  - clog2-based width helper for the pulse counter
- One natural sub-module: done_capture_reg (N_CH sticky set/clear flag register with mask, outputs all_done). FSM, pulse counter and watchdog stay in the top.

Test Plan:
- Reset, mask=5'b11111; sig=5'b11111 in one cycle → sig_out=1 for exactly 1 cycle on the next cycle, then DONE, busy=0; a second sig burst gives no pulse.
- Staggered reports with sig bits 0,2,4,1,3 in separate cycles → done_flags accumulates 00001→11111; sig_out rises one cycle after bit 3 arrives.
- mask=5'b00111, only bits 0..2 pulsed → completion; with PULSE_LEN=4, sig_out is high for 4 cycles.
- ONE_SHOT=0, three completion bursts 20 cycles apart → three pulses; done_flags is 0 after each pulse.
- timeout_cycles=10, only bit 0 reported → timeout=1 after 10 ARMED cycles, sig_out never asserts; start → timeout=0, busy=1.
- Corner events:
  - start in the same cycle as the final report → no pulse, flags cleared.
  - rst asserted mid-pulse → sig_out=0 immediately (asynchronous).
